// File: rtl/fft64_ctrl_pkg.sv
// rtl/fft64_ctrl_pkg.sv - shared types and constants for the 64-point FFT control path
package fft64_ctrl_pkg;

    // Frame sequencing state: waiting for a start-of-frame, or inside a frame
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fft64_state_e;

    localparam int FFT64_N     = 64;
    localparam int FFT64_IDX_W = 6;

    // Index of the final sample of a frame
    localparam logic [FFT64_IDX_W-1:0] FFT64_LAST_IDX = FFT64_IDX_W'(FFT64_N - 1);

endpackage

// File: rtl/dif_radix2_64p_tm_seq.sv
// rtl/dif_radix2_64p_tm_seq.sv - control sequencer for the 64-point DIF radix-2 twiddle-multiplier stage
module dif_radix2_64p_tm_seq
    import fft64_ctrl_pkg::*;
#(
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic                   in_ready,
    input  logic                   bypass,
    output logic [FFT64_IDX_W-1:0] tm64_ctrl,
    output logic                   halt_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   sof_err,
    output logic [7:0]             frame_cnt
);

    // Row-major uses the sample index directly; column-major swaps the
    // two 3-bit digits so the twiddle walks the 8x8 decomposition by column.
    function automatic logic [FFT64_IDX_W-1:0] permute_idx(input logic [FFT64_IDX_W-1:0] idx);
        if (COL_MAJOR) begin
            return {idx[2:0], idx[5:3]};
        end
        return idx;
    endfunction

    fft64_state_e             state_q, state_d;
    logic [FFT64_IDX_W-1:0]   cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sof_q, out_sof_d;
    logic                     out_eof_q, out_eof_d;
    logic                     sof_err_q, sof_err_d;
    logic [7:0]               frame_cnt_q, frame_cnt_d;

    logic                     in_ready_w;
    logic                     xfer;
    logic                     halt_w;
    logic [FFT64_IDX_W-1:0]   cur_idx;

    // Handshake decode: a sample is taken whenever the multiplier register is
    // free or being drained this cycle; only in-frame samples (or a new SOF)
    // load the multiplier. A SOF sample is always index 0, even mid-frame.
    always_comb begin
        in_ready_w = ~out_valid_q | out_ready;
        xfer       = in_valid & in_ready_w;
        halt_w     = xfer & ((state_q == ST_RUN) | in_sof) & ~rst;
        cur_idx    = in_sof ? '0 : cnt_q;
    end

    assign in_ready  = in_ready_w;
    assign halt_ctrl = halt_w;
    assign tm64_ctrl = (bypass | rst) ? '0 : permute_idx(cur_idx);
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign sof_err   = sof_err_q;
    assign frame_cnt = frame_cnt_q;

    // State registers; reset abandons any frame and drops out_valid at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            sof_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            sof_err_q   <= sof_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state: frame counter/FSM advance on loads; the output stage mirrors
    // the multiplier register, so markers travel with out_valid.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        sof_err_d   = sof_err_q;
        frame_cnt_d = frame_cnt_q;

        if (halt_w) begin
            if (in_sof) begin
                // A SOF inside a running frame restarts it; the partial frame is dropped
                if (state_q == ST_RUN) begin
                    sof_err_d = 1'b1;
                end
                state_d = ST_RUN;
                cnt_d   = FFT64_IDX_W'(1);
            end else if (cnt_q == FFT64_LAST_IDX) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q + FFT64_IDX_W'(1);
            end

            out_valid_d = 1'b1;
            out_sof_d   = (cur_idx == '0);
            out_eof_d   = (cur_idx == FFT64_LAST_IDX);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

endmodule

// File: doc/dif_radix2_64p_tm_seq.md
# dif_radix2_64p_tm_seq

Sequencer that drives the control side of the 64-point DIF radix-2 twiddle-multiplier stage. Accepts a framed sample stream with a valid/ready handshake, and generates the stage's `tm64_ctrl` index and `halt_ctrl` enable for each accepted sample. Produces a downstream valid/ready handshake with start-of-frame and end-of-frame markers aligned to the multiplier's one-cycle registered output. Sits between the preceding butterfly stage and the twiddle multiplier; sample data bypasses this block and goes directly to the multiplier.

## Interface
- `COL_MAJOR`, default 0: 0 → `tm64_ctrl` = cnt[5:0]; 1 → `tm64_ctrl` = {cnt[2:0], cnt[5:3]}.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `in_valid`  in  1  upstream sample valid.
- `in_sof`  in  1  marks sample 0 of a frame; qualified by `in_valid`.
- `in_ready`  out  1  upstream may transfer.
- `bypass`  in  1  force `tm64_ctrl`=0 (unity twiddle) while high.
- `tm64_ctrl`  out  6  twiddle index to multiplier; combinational from counter.
- `halt_ctrl`  out  1  multiplier load enable = accepted in-frame sample.
- `out_valid`  out  1  multiplier output register holds an unconsumed sample.
- `out_ready`  in  1  downstream accepts.
- `out_sof` / `out_eof`  out  1 each  markers for the sample at multiplier output.
- `sof_err`  out  1  sticky; SOF seen mid-frame.
- `frame_cnt`  out  8  completed frames, wraps 255→0.

## Operation
- States: IDLE (await SOF), RUN (frame in progress). The 6-bit counter `cnt` counts accepted in-frame samples.
- `in_ready` = !out_valid | out_ready. A transfer occurs when `xfer` = in_valid & in_ready.
- IDLE:
  - `xfer` with `in_sof` → `halt_ctrl`=1, `cnt` 0→1, go to RUN.
  - `xfer` without `in_sof` → sample discarded: `halt_ctrl`=0, no state change.
- RUN:
  - `xfer` → `halt_ctrl`=1, `cnt`++.
  - Transfer of `cnt`=63 → `cnt`=0, `frame_cnt`++, go to IDLE.
- SOF in RUN: `sof_err`←1 (sticky until `rst`). The sample is treated as index 0: `cnt`←1, stay in RUN, and the partial frame is not counted.
- `tm64_ctrl` reflects the index of the sample currently being presented. If `halt_ctrl`=0, its value is don't-care. `bypass` forces it to 0.
- `halt_ctrl` = xfer & (RUN | in_sof). The block never asserts it while the multiplier output is stalled.
- Output handshake:
  - `out_valid` ← 1 on a `halt_ctrl` cycle.
  - Else `out_valid` ← 0 if `out_ready`.
  - Else `out_valid` holds.
  - `out_sof` / `out_eof` load with `out_valid`: index 0 / index 63.
- Simultaneous `out_ready` and new `halt_ctrl`: `out_valid` stays 1 with no bubble.
- Back-to-back frames: SOF is accepted in IDLE on the cycle right after index 63.

## Timing
- Reset values: state IDLE, `cnt`=0, `out_valid`=0, `out_sof`=0, `out_eof`=0, `sof_err`=0, `frame_cnt`=0.
  - During reset: `halt_ctrl`=0, `tm64_ctrl`=0, `in_ready`=1.
- Control latency is 0: `tm64_ctrl` and `halt_ctrl` are valid in the same cycle as the input transfer.
- Output markers have 1-cycle latency, matching the multiplier register.
- Throughput: 1 sample/cycle while `out_ready`=1.
- Reset mid-frame: the frame is abandoned and `out_valid` drops asynchronously. The next frame requires SOF.

## Structure
- Shared package `fft64_ctrl_pkg` holds:
  - state enum IDLE/RUN;
  - `FFT64_N`=64;
  - `FFT64_IDX_W`=6.
  Both the multiplier stage's control decode and this block use it.
- Single module; no sub-module is warranted. The index permutation is a local function.

## Test plan
- Reset, then SOF plus 64 contiguous samples with `out_ready`=1:
  - `tm64_ctrl` runs 0..63;
  - `halt_ctrl` is high for 64 cycles;
  - `out_sof` is high 1 cycle after the first transfer, `out_eof` 1 cycle after the last;
  - `frame_cnt`=1.
- `COL_MAJOR`=1, sample `cnt`=9 → `tm64_ctrl`=6'b001001. `bypass`=1 → `tm64_ctrl`=0.
- Hold `out_ready`=0 after index 5:
  - `in_ready`=0 and `halt_ctrl`=0;
  - `out_valid` stays 1 with unchanged markers;
  - after release, index 6 follows without loss or duplication.
- SOF at index 20 → `sof_err`=1, `tm64_ctrl`=0, next index 1, `frame_cnt` unchanged. `sof_err` stays 1 after a later clean frame.
- Samples without SOF in IDLE: 3 transfers give `halt_ctrl`=0 and `out_valid`=0, then SOF starts at index 0.
- Assert `rst` at index 40: all outputs reach reset values immediately. After release, a full frame completes with `frame_cnt`=1.
